// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan receiver: segment codes (active-low,
// bit6=a .. bit0=g) and the digit-change event record.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // idx is sized for the largest supported display (up to 256 digits)
    typedef struct packed {
        logic [7:0] idx;
        logic [3:0] val;
        logic       blank;
    } seg7_event_t;

endpackage

// File: rtl/seg7_scan_rx_if.sv
// Valid/ready event stream carrying digit-change events out of seg7_scan_rx.
interface seg7_scan_rx_if #(
    parameter int IDXW = 3
);
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_idx;
    logic [3:0]      out_val;
    logic            out_blank;

    modport master (output out_valid, out_idx, out_val, out_blank, input out_ready);
    modport slave  (input out_valid, out_idx, out_val, out_blank, output out_ready);
endinterface

// File: rtl/seg7_dec.sv
// Inverse of the BCD-to-segment table: recovers the digit, a blank, or flags
// any pattern that the display driver can never produce.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] val,
    output logic       blank,
    output logic       bad
);

    // Pattern lookup; unknown patterns are reported rather than guessed
    always_comb begin
        val   = 4'd0;
        blank = 1'b0;
        bad   = 1'b0;
        case (seg)
            SEG_0:     val   = 4'd0;
            SEG_1:     val   = 4'd1;
            SEG_2:     val   = 4'd2;
            SEG_3:     val   = 4'd3;
            SEG_4:     val   = 4'd4;
            SEG_5:     val   = 4'd5;
            SEG_6:     val   = 4'd6;
            SEG_7:     val   = 4'd7;
            SEG_8:     val   = 4'd8;
            SEG_9:     val   = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// Receive side of the multiplexed 7-segment bus: debounces each scan slot,
// decodes it back to BCD per digit and queues digit-change events.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int NDIG   = 8,
    parameter int STABLE = 4,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_i,
    input  logic [NDIG-1:0]     an_i,
    output logic [4*NDIG-1:0]   digits_o,
    output logic [NDIG-1:0]     blank_o,
    output logic                err_o,
    output logic                ovf_o,
    seg7_scan_rx_if.master      ev
);

    localparam int IDXW = $clog2(NDIG);
    localparam int CNTW = $clog2(STABLE + 1);
    localparam int AW   = $clog2(DEPTH);

    logic [NDIG-1:0] s_an_r;
    logic [6:0]      s_seg_r;
    logic [CNTW-1:0] cnt_r;
    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;
    seg7_event_t     mem_r [DEPTH];

    logic            same_s, commit_s, changed_s, push_s, write_s, pop_s;
    logic            full_s, empty_s;
    logic [IDXW-1:0] idx_s;
    logic [3:0]      dec_val_s;
    logic            dec_blank_s, dec_bad_s;
    seg7_event_t     wr_ev_s, head_s;
    logic            unused_idx_hi_s;

    seg7_dec u_dec (
        .seg   (s_seg_r),
        .val   (dec_val_s),
        .blank (dec_blank_s),
        .bad   (dec_bad_s)
    );

    // Commit qualification, change detection and FIFO flags
    always_comb begin
        same_s   = ({an_i, seg_i} == {s_an_r, s_seg_r});
        // commit fires only on the count step into STABLE, so once per stable period
        commit_s = same_s && (cnt_r == CNTW'(STABLE - 1)) && $onehot(~s_an_r);
        idx_s    = {IDXW{1'b0}};
        for (int k = 0; k < NDIG; k++) begin
            idx_s = idx_s | (s_an_r[k] ? {IDXW{1'b0}} : IDXW'(k));
        end
        changed_s = (digits_o[{idx_s, 2'b00} +: 4] != dec_val_s) ||
                    (blank_o[idx_s] != dec_blank_s);
        push_s    = commit_s && !dec_bad_s && changed_s;
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r == {~rd_ptr_r[AW], rd_ptr_r[AW-1:0]});
        pop_s     = !empty_s && ev.out_ready;
        write_s   = push_s && (!full_s || pop_s);
        wr_ev_s   = '{idx: 8'(idx_s), val: dec_val_s, blank: dec_blank_s};
        head_s    = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Sample register and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an_r  <= {NDIG{1'b1}};
            s_seg_r <= 7'b1111111;
            cnt_r   <= {CNTW{1'b0}};
        end else if (!same_s) begin
            s_an_r  <= an_i;
            s_seg_r <= seg_i;
            cnt_r   <= {CNTW{1'b0}};
        end else if (cnt_r < CNTW'(STABLE)) begin
            cnt_r   <= cnt_r + CNTW'(1);
        end
    end

    // Stored digits and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_o <= {(4*NDIG){1'b0}};
            blank_o  <= {NDIG{1'b1}};
            err_o    <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            if (push_s) begin
                digits_o[{idx_s, 2'b00} +: 4] <= dec_val_s;
                blank_o[idx_s]                <= dec_blank_s;
            end
            if (commit_s && dec_bad_s) begin
                err_o <= 1'b1;
            end
            if (push_s && full_s && !pop_s) begin
                ovf_o <= 1'b1;
            end
        end
    end

    // FIFO pointers; the extra MSB separates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // FIFO storage needs no reset: contents are only visible when not empty
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_ev_s;
        end
    end

    assign ev.out_valid    = !empty_s;
    assign ev.out_idx      = head_s.idx[IDXW-1:0];
    assign ev.out_val      = head_s.val;
    assign ev.out_blank    = head_s.blank;
    assign unused_idx_hi_s = ^head_s.idx;

endmodule
